traffic_phase_scheduler: RTL and testbench

- Tick-driven phase sequencer for a main/cross junction with a pedestrian crossing.
- Adds yellow and all-red clearance phases, demand-actuated main-road hold, and round-robin arbitration between cross-road vehicle demand and pedestrian demand.
- Runs entirely on the board clock `clk`. It advances only on the `tick` enable pulse, which is one `clk` cycle wide, once per second, from the existing 1 s divider. It does not use a derived clock.
- Outputs drive the lamp pins, the walk lamp and the seven-segment countdown decoder.

---
 rtl/traffic_phase_scheduler.sv | 139 +++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Tick-driven main/cross/pedestrian phase sequencer with clearance phases,
// demand-actuated main-road hold and round-robin car/pedestrian arbitration.
module traffic_phase_scheduler #(
  parameter int MG_MIN    = 7,
  parameter int Y_TIME    = 2,
  parameter int AR_TIME   = 1,
  parameter int CG_TIME   = 5,
  parameter int WALK_TIME = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_cross,
  input  logic       ped_req,
  output logic       MG,
  output logic       MY,
  output logic       MR,
  output logic       CG,
  output logic       CY,
  output logic       CR,
  output logic       walk,
  output logic [3:0] count,
  output logic [2:0] phase
);

  // state        | meaning
  // MAIN_GREEN   | main road green, holds at count 0 until demand
  // MAIN_YELLOW  | main road yellow
  // ALL_RED_A    | clearance, picks car or pedestrian service
  // CROSS_GREEN  | cross road green
  // CROSS_YELLOW | cross road yellow
  // PED_WALK     | pedestrian walk, all vehicles red
  // ALL_RED_B    | clearance before returning to main green
  // ILLEGAL      | unreachable encoding, recovers to MAIN_GREEN
  typedef enum logic [2:0] {
    MAIN_GREEN   = 3'd0,
    MAIN_YELLOW  = 3'd1,
    ALL_RED_A    = 3'd2,
    CROSS_GREEN  = 3'd3,
    CROSS_YELLOW = 3'd4,
    PED_WALK     = 3'd5,
    ALL_RED_B    = 3'd6,
    ILLEGAL      = 3'd7
  } state_t;

  state_t     state, state_nx;
  logic [3:0] count_nx;
  logic       car_pend, car_nx;
  logic       ped_pend, ped_nx;
  logic       last_srv, last_nx;
  logic [6:0] lamps, lamps_nx;  // {MG,MY,MR,CG,CY,CR,walk}

  function automatic logic [3:0] dur_m1(input state_t s);
    case (s)
      MAIN_YELLOW, CROSS_YELLOW: dur_m1 = 4'(Y_TIME - 1);
      ALL_RED_A, ALL_RED_B:      dur_m1 = 4'(AR_TIME - 1);
      CROSS_GREEN:               dur_m1 = 4'(CG_TIME - 1);
      PED_WALK:                  dur_m1 = 4'(WALK_TIME - 1);
      default:                   dur_m1 = 4'(MG_MIN - 1);
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    count_nx = count;
    car_nx   = car_pend;
    ped_nx   = ped_pend;
    last_nx  = last_srv;
    lamps_nx = 7'b1000010;

    if (state == ILLEGAL) begin
      state_nx = MAIN_GREEN;
      count_nx = 4'(MG_MIN - 1);
    end else if (tick) begin
      if (count != 4'd0) begin
        count_nx = count - 4'd1;
      end else begin
        case (state)
          MAIN_GREEN:   if (car_pend || ped_pend) state_nx = MAIN_YELLOW;
          MAIN_YELLOW:  state_nx = ALL_RED_A;
          ALL_RED_A: begin
            // on a tie, serve whichever type did not go last
            if (car_pend && ped_pend) state_nx = last_srv ? CROSS_GREEN : PED_WALK;
            else if (car_pend)        state_nx = CROSS_GREEN;
            else if (ped_pend)        state_nx = PED_WALK;
            else                      state_nx = ALL_RED_B;
          end
          CROSS_GREEN:  state_nx = CROSS_YELLOW;
          CROSS_YELLOW: state_nx = ALL_RED_B;
          PED_WALK:     state_nx = ALL_RED_B;
          default:      state_nx = MAIN_GREEN;
        endcase
        if (state_nx != state) count_nx = dur_m1(state_nx);
      end
    end

    if (car_cross && state != CROSS_GREEN && state != CROSS_YELLOW) car_nx = 1'b1;
    if (ped_req && state != PED_WALK) ped_nx = 1'b1;
    if (state_nx == CROSS_GREEN && state != CROSS_GREEN) begin
      car_nx  = 1'b0;
      last_nx = 1'b0;
    end
    if (state_nx == PED_WALK && state != PED_WALK) begin
      ped_nx  = 1'b0;
      last_nx = 1'b1;
    end

    case (state_nx)
      MAIN_YELLOW:          lamps_nx = 7'b0100010;
      ALL_RED_A, ALL_RED_B: lamps_nx = 7'b0010010;
      CROSS_GREEN:          lamps_nx = 7'b0011000;
      CROSS_YELLOW:         lamps_nx = 7'b0010100;
      PED_WALK:             lamps_nx = 7'b0010011;
      default:              lamps_nx = 7'b1000010;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MAIN_GREEN;
      count    <= 4'(MG_MIN - 1);
      car_pend <= 1'b0;
      ped_pend <= 1'b0;
      last_srv <= 1'b1;
      lamps    <= 7'b1000010;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      car_pend <= car_nx;
      ped_pend <= ped_nx;
      last_srv <= last_nx;
      lamps    <= lamps_nx;
    end
  end

  assign {MG, MY, MR, CG, CY, CR, walk} = lamps;
  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: a phase-table reference model predicts every cycle's
// outputs; a negedge monitor compares the DUT against the queued predictions.
module tb_traffic_phase_scheduler;

  localparam int MG_MIN = 7, Y_TIME = 2, AR_TIME = 1, CG_TIME = 5, WALK_TIME = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, tick = 1'b0, car_cross = 1'b0, ped_req = 1'b0;
  logic       MG, MY, MR, CG, CY, CR, walk;
  logic [3:0] count;
  logic [2:0] phase;

  traffic_phase_scheduler #(
    .MG_MIN(MG_MIN), .Y_TIME(Y_TIME), .AR_TIME(AR_TIME),
    .CG_TIME(CG_TIME), .WALK_TIME(WALK_TIME)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .car_cross(car_cross), .ped_req(ped_req),
    .MG(MG), .MY(MY), .MR(MR), .CG(CG), .CY(CY), .CR(CR), .walk(walk),
    .count(count), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // phase index -> duration and lamp pattern {MG,MY,MR,CG,CY,CR,walk}
  int         dur_tbl  [7];
  logic [6:0] lamp_tbl [7];
  initial begin
    dur_tbl  = '{MG_MIN, Y_TIME, AR_TIME, CG_TIME, Y_TIME, WALK_TIME, AR_TIME};
    lamp_tbl = '{7'b1000010, 7'b0100010, 7'b0010010, 7'b0011000,
                 7'b0010100, 7'b0010011, 7'b0010010};
  end

  int m_phase = 0, m_cnt = MG_MIN - 1;
  bit m_car = 0, m_ped = 0, m_last = 1;

  logic [13:0] sb[$];  // {phase, count, lamps}

  function automatic int successor(int p, bit car, bit ped, bit last);
    case (p)
      0: return (car || ped) ? 1 : 0;
      1: return 2;
      2: begin
        if (car && ped) return last ? 3 : 5;
        if (car) return 3;
        if (ped) return 5;
        return 6;
      end
      3: return 4;
      4: return 6;
      5: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit t, input bit c, input bit p);
    int old, nxt;
    if (r) begin
      m_phase = 0; m_cnt = MG_MIN - 1; m_car = 0; m_ped = 0; m_last = 1;
      return;
    end
    old = m_phase;
    nxt = old;
    if (t) begin
      if (m_cnt > 0) m_cnt--;
      else begin
        nxt = successor(old, m_car, m_ped, m_last);
        if (nxt != old) m_cnt = dur_tbl[nxt] - 1;
      end
    end
    if (c && old != 3 && old != 4) m_car = 1;
    if (p && old != 5) m_ped = 1;
    if (nxt == 3 && old != 3) begin m_car = 0; m_last = 0; end
    if (nxt == 5 && old != 5) begin m_ped = 0; m_last = 1; end
    m_phase = nxt;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clk cycle; inputs applied before the edge, returns 1 time unit after it
  task automatic do_cycle(input bit r, input bit t, input bit c, input bit p);
    reset = r; tick = t; car_cross = c; ped_req = p;
    @(posedge clk);
    model_step(r, t, c, p);
    sb.push_back({3'(m_phase), 4'(m_cnt), lamp_tbl[m_phase]});
    #1;
  endtask

  task automatic ticks(input int n, input bit car);
    for (int i = 0; i < n; i++) begin
      do_cycle(0, 1, car, 0);
      do_cycle(0, 0, car, 0);
    end
  endtask

  task automatic chk_state(input string name, input int ph, input int cnt);
    chk({name, ".phase"}, int'(phase), ph);
    chk({name, ".count"}, int'(count), cnt);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [13:0] exp;
      exp = sb.pop_front();
      checks++;
      if ({phase, count, MG, MY, MR, CG, CY, CR, walk} !== exp) begin
        errors++;
        $display("FAIL scoreboard: got ph=%0d cnt=%0d lamps=%b expected ph=%0d cnt=%0d lamps=%b at %0t",
                 phase, count, {MG, MY, MR, CG, CY, CR, walk},
                 exp[13:11], exp[10:7], exp[6:0], $time);
      end
    end
  end

  initial begin
    int guard;
    bit found;
    bit car_lvl;

    // idle: count runs down and holds at 0
    do_cycle(1, 1, 0, 0);
    chk_state("reset", 0, 6);
    chk("reset.lamps", int'({MG, MY, MR, CG, CY, CR, walk}), 7'b1000010);
    ticks(20, 0);
    chk_state("idle_hold", 0, 0);

    // single car pulse before tick 3
    do_cycle(1, 0, 0, 0);
    ticks(2, 0);
    do_cycle(0, 0, 1, 0);
    ticks(4, 0);
    chk_state("car.t6", 0, 0);
    ticks(1, 0);
    chk_state("car.my", 1, 1);
    ticks(2, 0);
    chk_state("car.ara", 2, 0);
    ticks(1, 0);
    chk_state("car.cg", 3, 4);
    chk("car.cg_lamp", int'(CG), 1);
    ticks(5, 0);
    chk_state("car.cy", 4, 1);
    ticks(2, 0);
    chk_state("car.arb", 6, 0);
    ticks(1, 0);
    chk_state("car.mg", 0, 6);
    ticks(20, 0);
    chk_state("car.cleared", 0, 0);

    // simultaneous car + ped: car first, then walk
    do_cycle(1, 0, 0, 0);
    do_cycle(0, 0, 1, 1);
    ticks(10, 0);
    chk_state("tie.cg", 3, 4);
    ticks(8, 0);
    chk_state("tie.back", 0, 6);
    ticks(6, 0);
    chk_state("tie.mg0", 0, 0);
    ticks(3, 0);
    chk_state("tie.ara", 2, 0);
    ticks(1, 0);
    chk_state("tie.walk", 5, 3);
    chk("tie.walk_lamp", int'(walk), 1);
    do_cycle(0, 0, 0, 1);
    ticks(4, 0);
    chk_state("tie.arb", 6, 0);
    ticks(1, 0);
    chk_state("tie.mg", 0, 6);
    ticks(30, 0);
    chk_state("tie.no_rewalk", 0, 0);

    // car held high: re-latches in ALL_RED_B only
    do_cycle(1, 0, 1, 0);
    ticks(18, 1);
    chk_state("hold.mg", 0, 6);
    ticks(6, 1);
    chk_state("hold.mg0", 0, 0);
    ticks(1, 1);
    chk_state("hold.my", 1, 1);

    // reset mid CROSS_GREEN at count 2
    found = 0;
    guard = 0;
    while (!found && guard < 400) begin
      do_cycle(0, guard[0], 1, 0);
      guard++;
      if (m_phase == 3 && m_cnt == 2) found = 1;
    end
    chk("rst_mid.reached", int'(found), 1);
    do_cycle(1, 1, 0, 0);
    chk_state("rst_mid", 0, 6);
    chk("rst_mid.MG", int'(MG), 1);
    chk("rst_mid.CG", int'(CG), 0);
    ticks(20, 0);
    chk_state("rst_mid.no_pend", 0, 0);

    // randomized traffic
    car_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) car_lvl = ~car_lvl;
      do_cycle($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0,
               car_lvl, $urandom_range(0, 24) == 0);
    end

    do_cycle(0, 0, 0, 0);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #6;
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
